// File: rtl/jpu_mem_arbiter.sv
// Two-master arbiter in front of one single-ported bus slave: fixed data (M0) priority,
// anti-starvation for instruction fetch (M1), one outstanding transaction, bus timeout.
module jpu_mem_arbiter #(
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned TW         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_mask,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_mask,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_we,
    output logic [29:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_mask,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant
);

    localparam int unsigned SW = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           resp, timeout, done;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            timer_q  <= timer_d;
        end
    end

    // Completion detection; a response coinciding with reset is dropped
    always_comb begin
        resp    = s_ack | s_err;
        timeout = (TIMEOUT != 0) && (state_q != IDLE) && !resp
                  && (timer_q == TW'(TIMEOUT - 1));
        done    = (state_q != IDLE) && (resp || timeout) && !rst;
    end

    // Next-state, arbitration and counter update
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (m0_req && m1_req) begin
                    state_d = (starve_q == SW'(MAX_STARVE)) ? BUSY1 : BUSY0;
                end else if (m0_req) begin
                    state_d = BUSY0;
                end else if (m1_req) begin
                    state_d = BUSY1;
                end
                if (state_d == BUSY1) begin
                    starve_d = '0;
                end else if (state_d == BUSY0 && m1_req && starve_q != SW'(MAX_STARVE)) begin
                    starve_d = starve_q + SW'(1);
                end
            end
            BUSY0, BUSY1: begin
                if (done) begin
                    state_d = IDLE;
                end
                // Saturating count keeps a stuck slave from wrapping past the limit
                if ((TIMEOUT != 0) && !resp && (timer_q != '1)) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux and master-side completion pass-through
    always_comb begin
        s_req    = (state_q != IDLE);
        s_we     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_mask   = '0;
        grant    = {state_q == BUSY1, state_q == BUSY0};
        m0_ack   = done && (state_q == BUSY0);
        m1_ack   = done && (state_q == BUSY1);
        m0_err   = m0_ack && (s_err || timeout);
        m1_err   = m1_ack && (s_err || timeout);
        m0_rdata = m0_ack ? s_rdata : '0;
        m1_rdata = m1_ack ? s_rdata : '0;
        case (state_q)
            BUSY0: begin
                s_we    = m0_we;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_mask  = m0_mask;
            end
            BUSY1: begin
                s_we    = m1_we;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_mask  = m1_mask;
            end
            default: ;
        endcase
    end

endmodule
